// File: rtl/sha256_msg_feeder_if.sv
// rtl/sha256_msg_feeder_if.sv - byte stream, core word-feed and digest signal bundle
interface sha256_msg_feeder_if;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic         core_start;
    logic         core_enable;
    logic [7:0]   core_num_blocks;
    logic         core_req_word;
    logic [5:0]   core_word_address;
    logic [7:0]   core_block_count;
    logic [31:0]  core_word_data;
    logic         core_word_valid;
    logic [255:0] core_hash;
    logic         core_hash_valid;
    logic [255:0] digest;
    logic         digest_valid;
    logic         digest_ready;
    logic         error;

    modport slave (
        input  s_data, s_valid, s_last, core_req_word, core_word_address,
               core_block_count, core_hash, core_hash_valid, digest_ready,
        output s_ready, core_start, core_enable, core_num_blocks, core_word_data,
               core_word_valid, digest, digest_valid, error
    );

    modport master (
        output s_data, s_valid, s_last, core_req_word, core_word_address,
               core_block_count, core_hash, core_hash_valid, digest_ready,
        input  s_ready, core_start, core_enable, core_num_blocks, core_word_data,
               core_word_valid, digest, digest_valid, error
    );
endinterface

// File: rtl/sha256_msg_feeder.sv
// rtl/sha256_msg_feeder.sv - buffers a message and serves padded SHA-256 words to the core
module sha256_msg_feeder #(
    parameter int MAX_BLOCKS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sha256_msg_feeder_if.slave bus
);
    localparam int DEPTH = MAX_BLOCKS * 64;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int PW    = 14;
    localparam logic [LW-1:0] LIMIT = LW'(DEPTH - 8);

    typedef enum logic [2:0] {IDLE, LOAD, START, FEED, DONE} state_t;

    state_t        state;
    logic [LW-1:0] len;
    logic [7:0]    mem [DEPTH];

    logic          accept;
    logic          discard;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [LW-1:0] len_inc;
    logic [LW-1:0] new_len;
    logic [7:0]    start_blocks;
    logic          sample;
    logic [11:0]   w_idx;
    logic [PW-1:0] t_bytes;
    logic [PW-1:0] pos;
    logic [63:0]   bit_len;
    logic [31:0]   word;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^bus.core_word_address[5:4];

    assign accept       = bus.s_valid & bus.s_ready;
    assign discard      = (state == LOAD) & bus.error;
    assign wr_en        = accept & ~discard;
    assign wr_addr      = (state == IDLE) ? '0 : len[AW-1:0];
    assign len_inc      = len + 1'b1;
    assign new_len      = (state == IDLE) ? LW'(1) : len_inc;
    assign start_blocks = 8'((new_len + LW'(8)) >> 6) + 8'd1;
    assign sample       = (state == FEED) & bus.core_req_word & ~bus.core_word_valid
                          & ~bus.core_hash_valid;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= bus.s_data;
    end

    // Padding is synthesised per byte; the length field sits in the last 8 bytes of the final block.
    always_comb begin
        word    = '0;
        pos     = '0;
        w_idx   = {bus.core_block_count, bus.core_word_address[3:0]};
        t_bytes = {bus.core_num_blocks, 6'b0};
        bit_len = {{(64-LW-3){1'b0}}, len, 3'b000};
        for (int k = 0; k < 4; k++) begin
            pos = {w_idx, 2'(k)};
            if (pos < PW'(len))
                word[31-8*k -: 8] = mem[pos[AW-1:0]];
            else if (pos == PW'(len))
                word[31-8*k -: 8] = 8'h80;
            else if ((pos >= t_bytes - PW'(8)) && (pos < t_bytes))
                word[31-8*k -: 8] = bit_len[8*(7 - int'(pos[2:0])) +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            len                 <= '0;
            bus.s_ready         <= 1'b0;
            bus.core_start      <= 1'b0;
            bus.core_enable     <= 1'b0;
            bus.core_num_blocks <= '0;
            bus.core_word_data  <= '0;
            bus.core_word_valid <= 1'b0;
            bus.digest          <= '0;
            bus.digest_valid    <= 1'b0;
            bus.error           <= 1'b0;
        end else begin
            bus.core_start      <= 1'b0;
            bus.core_enable     <= 1'b0;
            bus.core_word_valid <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    bus.s_ready <= 1'b1;
                    if (accept) begin
                        if (state == IDLE) bus.error <= 1'b0;
                        if (discard) begin
                            if (bus.s_last) begin
                                state <= IDLE;
                                len   <= '0;
                            end
                        end else if (new_len >= LIMIT) begin
                            bus.error <= 1'b1;
                            len       <= new_len;
                            state     <= bus.s_last ? IDLE : LOAD;
                        end else begin
                            len <= new_len;
                            if (bus.s_last) begin
                                state               <= START;
                                bus.s_ready         <= 1'b0;
                                bus.core_start      <= 1'b1;
                                bus.core_enable     <= 1'b1;
                                bus.core_num_blocks <= start_blocks;
                            end else begin
                                state <= LOAD;
                            end
                        end
                    end
                end
                START: state <= FEED;
                FEED: begin
                    if (bus.core_hash_valid) begin
                        bus.digest       <= bus.core_hash;
                        bus.digest_valid <= 1'b1;
                        state            <= DONE;
                    end else if (sample) begin
                        bus.core_word_data  <= word;
                        bus.core_word_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.digest_ready) begin
                        bus.digest_valid <= 1'b0;
                        bus.s_ready      <= 1'b1;
                        len              <= '0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_msg_feeder.sv
// tb/tb_sha256_msg_feeder.sv - self-checking bench for sha256_msg_feeder
module tb_sha256_msg_feeder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sha256_msg_feeder_if bus_if();
    sha256_msg_feeder #(.MAX_BLOCKS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    typedef struct {
        int          len;
        int          nb;
        int          blk;
        int          addr;
        logic [31:0] exp;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         start_cnt = 0;
    logic [7:0] msg_q[$];
    logic [7:0] pad_q[$];
    vec_t       vecs[$];

    always @(negedge clk) if (bus_if.core_start) start_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference padding: message, 0x80, zeros to 56 mod 64, then 64-bit big-endian bit length.
    function automatic void build_pad();
        longint unsigned bits = longint'(msg_q.size()) * 8;
        pad_q = msg_q;
        pad_q.push_back(8'h80);
        while (pad_q.size() % 64 != 56) pad_q.push_back(8'h00);
        for (int i = 7; i >= 0; i--) pad_q.push_back(8'(bits >> (8 * i)));
    endfunction

    function automatic logic [31:0] model_word(input int w);
        return {pad_q[4*w], pad_q[4*w+1], pad_q[4*w+2], pad_q[4*w+3]};
    endfunction

    function automatic void make_seq(input int n);
        msg_q = {};
        for (int i = 0; i < n; i++) msg_q.push_back(8'(i + 1));
        build_pad();
    endfunction

    task automatic send_msg();
        int i = 0;
        int budget = 0;
        while (i < msg_q.size() && budget < 2000) begin
            @(negedge clk);
            budget++;
            bus_if.s_data  = msg_q[i];
            bus_if.s_last  = (i == msg_q.size() - 1);
            bus_if.s_valid = ($urandom_range(0, 3) != 0);
            if (bus_if.s_valid && bus_if.s_ready) i++;
        end
        if (i < msg_q.size()) chk("send_timeout", i, msg_q.size());
        @(negedge clk);
        bus_if.s_valid = 1'b0;
        bus_if.s_last  = 1'b0;
    endtask

    task automatic check_start(input string tag);
        chk({tag, "_core_start"}, bus_if.core_start, 1'b1);
        chk({tag, "_core_enable"}, bus_if.core_enable, 1'b1);
        chk({tag, "_num_blocks"}, bus_if.core_num_blocks, pad_q.size() / 64);
        chk({tag, "_s_ready_low"}, bus_if.s_ready, 1'b0);
    endtask

    task automatic read_word(input int blk, input int addr, output logic [31:0] data);
        int  n = 0;
        bit  got = 0;
        data = 'x;
        bus_if.core_block_count  = 8'(blk);
        bus_if.core_word_address = {2'($urandom_range(0, 3)), 4'(addr)};
        bus_if.core_req_word     = 1'b1;
        while (n < 8 && !got) begin
            @(negedge clk);
            n++;
            if (bus_if.core_word_valid) begin
                got  = 1;
                data = bus_if.core_word_data;
            end
        end
        bus_if.core_req_word = 1'b0;
    endtask

    task automatic finish_digest(input logic [255:0] h, input int hold);
        int bad = 0;
        @(negedge clk);
        bus_if.core_hash         = h;
        bus_if.core_hash_valid   = 1'b1;
        bus_if.core_req_word     = 1'b1;
        bus_if.core_block_count  = 8'd0;
        bus_if.core_word_address = 6'd0;
        @(negedge clk);
        bus_if.core_hash_valid = 1'b0;
        chk("digest_valid_rise", bus_if.digest_valid, 1'b1);
        chk("digest_value", bus_if.digest, h);
        chk("req_with_hash_dropped", bus_if.core_word_valid, 1'b0);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (!bus_if.digest_valid || bus_if.s_ready || bus_if.core_word_valid) bad++;
        end
        if (hold > 0) chk("digest_hold", bad, 0);
        bus_if.core_req_word = 1'b0;
        bus_if.digest_ready  = 1'b1;
        @(negedge clk);
        bus_if.digest_ready = 1'b0;
        chk("digest_accepted", bus_if.digest_valid, 1'b0);
        chk("idle_s_ready", bus_if.s_ready, 1'b1);
    endtask

    task automatic run_abc(input int hold);
        logic [31:0] d;
        msg_q = {8'h61, 8'h62, 8'h63};
        build_pad();
        send_msg();
        check_start("abc");
        for (int a = 0; a < 16; a++) begin
            read_word(0, a, d);
            if (a == 0) chk("abc_w0", d, 32'h61626380);
            else if (a == 15) chk("abc_w15", d, 32'h00000018);
            else chk($sformatf("abc_w%0d", a), d, 32'h0);
        end
        finish_digest(ABC_DIGEST, hold);
    endtask

    initial begin
        logic [31:0] d;
        int          s0;
        int          nvalid;
        int          b2b;
        bit          prev;
        int          nb;

        bus_if.s_data = '0; bus_if.s_valid = 0; bus_if.s_last = 0;
        bus_if.core_req_word = 0; bus_if.core_word_address = '0; bus_if.core_block_count = '0;
        bus_if.core_hash = '0; bus_if.core_hash_valid = 0; bus_if.digest_ready = 0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus_if.s_ready, bus_if.core_start, bus_if.core_enable,
            bus_if.core_num_blocks, bus_if.core_word_valid, bus_if.core_word_data,
            bus_if.digest_valid, bus_if.error}, '0);
        chk("reset_digest", bus_if.digest, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("s_ready_after_reset", bus_if.s_ready, 1'b1);

        run_abc(10);

        // Continuous request: one valid every second cycle, never back to back.
        msg_q = {8'h61, 8'h62, 8'h63};
        build_pad();
        send_msg();
        @(negedge clk);
        bus_if.core_block_count = 0; bus_if.core_word_address = 0; bus_if.core_req_word = 1;
        nvalid = 0; b2b = 0; prev = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus_if.core_word_valid) begin
                nvalid++;
                if (prev) b2b++;
                if (bus_if.core_word_data !== model_word(0)) b2b++;
            end
            prev = bus_if.core_word_valid;
        end
        bus_if.core_req_word = 0;
        chk("hold_req_valid_count", nvalid, 10);
        chk("hold_req_back_to_back", b2b, 0);
        finish_digest({8{$urandom}}, 0);

        vecs.push_back(vec_t'{55, 1, 0, 13, 32'h35363780});
        vecs.push_back(vec_t'{55, 1, 0, 15, 32'h000001B8});
        vecs.push_back(vec_t'{55, 1, 0, 14, 32'h00000000});
        vecs.push_back(vec_t'{56, 2, 0, 13, 32'h35363738});
        vecs.push_back(vec_t'{56, 2, 0, 14, 32'h80000000});
        vecs.push_back(vec_t'{56, 2, 1, 15, 32'h000001C0});
        vecs.push_back(vec_t'{64, 2, 0, 15, 32'h3D3E3F40});
        vecs.push_back(vec_t'{64, 2, 1, 0,  32'h80000000});
        vecs.push_back(vec_t'{64, 2, 1, 15, 32'h00000200});
        vecs.push_back(vec_t'{1,  1, 0, 0,  32'h01800000});
        vecs.push_back(vec_t'{1,  1, 0, 15, 32'h00000008});
        vecs.push_back(vec_t'{247, 4, 3, 13, 32'hF5F6F780});
        vecs.push_back(vec_t'{247, 4, 3, 15, 32'h000007B8});
        vecs.push_back(vec_t'{247, 4, 3, 14, 32'h00000000});
        foreach (vecs[i]) begin
            make_seq(vecs[i].len);
            send_msg();
            chk($sformatf("vec%0d_num_blocks", i), bus_if.core_num_blocks, vecs[i].nb);
            read_word(vecs[i].blk, vecs[i].addr, d);
            chk($sformatf("vec%0d_len%0d_b%0d_w%0d", i, vecs[i].len, vecs[i].blk, vecs[i].addr),
                d, vecs[i].exp);
            finish_digest({8{$urandom}}, 0);
        end

        for (int r = 0; r < 6; r++) begin
            msg_q = {};
            for (int i = 0; i < $urandom_range(1, 247); i++) msg_q.push_back(8'($urandom));
            build_pad();
            send_msg();
            check_start($sformatf("rnd%0d", r));
            nb = pad_q.size() / 64;
            for (int q = 0; q < 12; q++) begin
                int b = $urandom_range(0, nb - 1);
                int a = $urandom_range(0, 15);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                read_word(b, a, d);
                chk($sformatf("rnd%0d_len%0d_b%0d_w%0d", r, msg_q.size(), b, a), d, model_word(16 * b + a));
            end
            finish_digest({8{$urandom}}, 0);
        end

        foreach (vecs[i]) if (i < 2) begin
            s0 = start_cnt;
            make_seq(i == 0 ? 248 : 252);
            send_msg();
            chk($sformatf("ovf%0d_error", i), bus_if.error, 1'b1);
            chk($sformatf("ovf%0d_idle_s_ready", i), bus_if.s_ready, 1'b1);
            repeat (3) @(negedge clk);
            chk($sformatf("ovf%0d_no_start", i), start_cnt - s0, 0);
        end
        run_abc(0);
        chk("error_cleared", bus_if.error, 1'b0);

        // Asynchronous reset while feeding.
        msg_q = {8'h61, 8'h62, 8'h63};
        build_pad();
        send_msg();
        read_word(0, 0, d);
        chk("pre_reset_word", d, 32'h61626380);
        @(negedge clk);
        bus_if.core_req_word = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {bus_if.s_ready, bus_if.core_start, bus_if.core_enable,
            bus_if.core_num_blocks, bus_if.core_word_valid, bus_if.core_word_data,
            bus_if.digest_valid, bus_if.error}, '0);
        chk("async_reset_digest", bus_if.digest, '0);
        bus_if.core_req_word = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("s_ready_after_midreset", bus_if.s_ready, 1'b1);
        run_abc(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sha256_msg_feeder.md
# sha256_msg_feeder

Front-end controller for the SHA-256 compression loop. It accepts a message as a byte stream and buffers it. It computes the block count and pulses the core's start/enable. It then answers every word request from the core with big-endian message words, generating the FIPS 180-4 padding and 64-bit length on the fly. When the core signals completion it captures the 256-bit digest and holds it on a ready/valid output until accepted.

## Interface
- MAX_BLOCKS, 4: maximum 512-bit blocks per message; data buffer is MAX_BLOCKS*64 bytes.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_data  in  8  message byte.
- s_valid  in  1  byte valid.
- s_last  in  1  marks final byte of message (qualified by s_valid).
- s_ready  out  1  feeder accepts byte this cycle.
- core_start  out  1  one-cycle start pulse to compression loop.
- core_enable  out  1  asserted together with core_start.
- core_num_blocks  out  8  block count, held stable from start until digest captured.
- core_req_word  in  1  core requests a message word.
- core_word_address  in  6  requested word; only bits [3:0] (word-in-block) are used.
- core_block_count  in  8  block index currently processed by the core.
- core_word_data  out  32  requested word.
- core_word_valid  out  1  one-cycle pulse, word_data valid.
- core_hash  in  256  digest from core.
- core_hash_valid  in  1  digest valid.
- digest  out  256  captured digest.
- digest_valid  out  1  digest available.
- digest_ready  in  1  consumer accepts digest.
- error  out  1  sticky overflow flag, cleared by next accepted first byte.

## Operation
- States: IDLE, LOAD, START, FEED, DONE.
- IDLE: s_ready=1. An accepted byte is stored at byte 0, byte count L=1, and the FSM goes to LOAD. If s_last is set on that byte, the FSM goes to START instead.
- LOAD: s_ready=1. Each accepted byte is stored at index L, and L increments. On an accepted byte with s_last, the FSM goes to START.
- Overflow: L reaching MAX_BLOCKS*64-8 bytes (the limit is MAX_BLOCKS*64-9 bytes) sets error. Further bytes are discarded until s_last, then the FSM returns to IDLE; the core is not started.
- START: the FSM computes core_num_blocks = floor((L+8)/64)+1 with 8-bit arithmetic. It asserts core_start=core_enable=1 for exactly one cycle, then goes to FEED. s_ready=0 in every state other than IDLE and LOAD.
- FEED, word serving: a sample occurs when core_req_word=1 and no valid was issued in the previous cycle.
  - On each sample, the feeder forms global word index w = core_block_count*16 + core_word_address[3:0].
  - Next cycle it drives core_word_data and pulses core_word_valid for one cycle.
  - The cycle after that pulse is always idle, so the core's address can advance. Throughput is one word per 2 cycles.
- Word composition: byte k (0..3) of the word lands in bits [31-8k -: 8], big-endian. Its byte position is p = 4w+k. Let T = core_num_blocks*64. Then:
  - p < L: the buffered data byte.
  - p == L: 0x80.
  - T-8 <= p < T: byte (p-(T-8)) of the 64-bit big-endian bit length L*8.
  - otherwise: 0x00.
- FEED, completion: core_hash_valid=1 captures core_hash into digest, sets digest_valid, and moves the FSM to DONE. core_req_word is ignored once the digest is captured.
- DONE: digest_valid=1 and digest is held. When digest_ready=1, digest_valid clears, L clears and the FSM returns to IDLE.
- Reset mid-operation: everything returns to reset values immediately and buffer contents are discarded. Buffer storage itself needs no reset.

## Timing
- Reset values:
  - s_ready=0 during reset, then 1 in IDLE the first cycle after release.
  - core_start=0, core_enable=0, core_num_blocks=0, core_word_data=0, core_word_valid=0.
  - digest=0, digest_valid=0, error=0. State=IDLE, L=0.
- Byte acceptance: s_valid & s_ready on a rising edge.
- The last-byte edge is followed by one START cycle in which core_start is high.
- Word latency: request sampled at edge t produces core_word_valid high in cycle t+1. The address is not re-sampled at edge t+1.
- A request arriving simultaneously with core_hash_valid is dropped.
- digest_valid rises the cycle after core_hash_valid. Handshake completion (valid&ready) returns the FSM to IDLE on the next edge.
- All outputs are registered.

## Test plan
- Message "abc" (0x61,0x62,0x63, s_last on 0x63):
  - core_num_blocks=1.
  - Word 0 = 0x61626380, words 1-14 = 0, word 15 = 0x00000018.
  - Digest (with core) = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- 55-byte message: num_blocks=1, word 13 = xx xx xx 80 (last data byte then 0x80), word 15 = 0x000001B8. 56-byte message: num_blocks=2, block 1 word 15 = 0x000001C0.
- Empty-length edge, 64-byte message: num_blocks=2, block 1 word 0 = 0x80000000, block 1 word 15 = 0x00000200.
- Overflow with MAX_BLOCKS=4, 248 bytes sent: error=1, core_start never asserts, FSM back in IDLE. Next accepted byte clears error.
- Handshake:
  - Hold core_req_word=1 continuously: core_word_valid pulses every 2nd cycle, never two in a row.
  - Hold digest_ready=0 for 10 cycles: digest_valid stays high and s_ready stays 0.
- Reset asserted during FEED: all outputs return to 0 asynchronously. After release, a fresh "abc" run produces the correct digest.
